// File: rtl/pio_edge_in_multi.sv
// pio_edge_in_multi: Avalon-MM input PIO with per-bit sync, debounce, sticky edge capture and maskable irq
module pio_edge_in_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16,
    parameter int DEB_RESET   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DEB_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] sync, stable, stable_q, rise_en, fall_en, irq_mask, edge_cap, hit, w1c;
    logic [DEB_W-1:0] debounce, lim;
    logic [31:0] rd_mux;
    logic irq_mode, wr, deb_wr, unused;
    assign wr = chipselect & ~write_n;
    assign deb_wr = wr && address == 3'd5;
    assign sync = sync_q[SYNC_STAGES-1];
    assign lim = (debounce == '0) ? '0 : debounce - DEB_W'(1);
    assign hit = (stable & ~stable_q & rise_en) | (~stable & stable_q & fall_en);
    assign w1c = (wr && address == 3'd3) ? WIDTH'(writedata) : '0;
    assign irq = irq_mode ? |(stable & irq_mask) : |(edge_cap & irq_mask);
    assign unused = ^writedata;
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = 32'(stable);
            3'd1:    rd_mux = 32'(rise_en);
            3'd2:    rd_mux = 32'(irq_mask);
            3'd3:    rd_mux = 32'(edge_cap);
            3'd4:    rd_mux = 32'(fall_en);
            3'd5:    rd_mux = 32'(debounce);
            3'd6:    rd_mux = 32'(irq_mode);
            default: rd_mux = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    // a bit flips only after sync has disagreed with it for lim+1 consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            stable_q <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] != stable[i] && cnt[i] == lim) stable[i] <= sync[i];
                cnt[i] <= (sync[i] == stable[i] || cnt[i] == lim || deb_wr) ? '0 : cnt[i] + DEB_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            debounce <= DEB_W'(DEB_RESET);
            irq_mode <= 1'b0;
            readdata <= '0;
        end else begin
            edge_cap <= (edge_cap & ~w1c) | hit;
            readdata <= rd_mux;
            if (wr) begin
                case (address)
                    3'd1:    rise_en  <= WIDTH'(writedata);
                    3'd2:    irq_mask <= WIDTH'(writedata);
                    3'd4:    fall_en  <= WIDTH'(writedata);
                    3'd5:    debounce <= DEB_W'(writedata);
                    3'd6:    irq_mode <= writedata[0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pio_edge_in_multi.sv
// tb_pio_edge_in_multi: scoreboard bench; reference model judges debounce from a history window of input samples
module tb_pio_edge_in_multi;
    localparam int W = 8, S = 2, HL = 64;
    logic clk = 0, reset = 1, chipselect = 0, write_n = 1, rd_req = 0, irq;
    logic [2:0] address = 0;
    logic [31:0] writedata = 0, readdata;
    logic [W-1:0] in_port = 0;
    int errors = 0, checks = 0;

    pio_edge_in_multi #(.WIDTH(W), .SYNC_STAGES(S), .DEB_W(16), .DEB_RESET(0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_st = 0, m_st_prev = 0, m_rise = 0, m_fall = 0, m_mask = 0, m_ecap = 0;
    logic [W-1:0] m_edges, m_nxt, m_w1c;
    logic [W-1:0] inq[$];
    logic [15:0] m_deb = 0;
    logic m_mode = 0, m_flip;
    logic [31:0] m_rd;
    int cyc = 0, last_clr = 0, m_lim;
    logic [31:0] exp_d[$];
    logic exp_irq[$];
    int exp_a[$];

    function automatic logic [31:0] reg_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_st);
            3'd1: return 32'(m_rise);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(m_ecap);
            3'd4: return 32'(m_fall);
            3'd5: return 32'(m_deb);
            3'd6: return 32'(m_mode);
            default: return 32'd0;
        endcase
    endfunction

    // reference model: a bit flips once the last L synchronised samples all disagree with it
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            if (rd_req) begin
                exp_a.push_back(int'(address));
                exp_d.push_back(32'd0);
                exp_irq.push_back(1'b0);
            end
            m_st = 0; m_st_prev = 0; m_rise = 0; m_fall = 0; m_mask = 0; m_ecap = 0; m_deb = 0; m_mode = 0;
            inq = {};
            for (int i = 0; i < HL; i++) inq.push_front('0);
            last_clr = cyc;
        end else begin
            m_rd = reg_read(address);
            m_edges = (m_st & ~m_st_prev & m_rise) | (~m_st & m_st_prev & m_fall);
            inq.push_front(in_port);
            void'(inq.pop_back());
            m_lim = (m_deb == 0) ? 1 : int'(m_deb);
            m_nxt = m_st;
            for (int b = 0; b < W; b++) begin
                m_flip = (cyc - last_clr >= m_lim);
                for (int k = 0; k < m_lim && S + k < HL; k++) if (inq[S+k][b] == m_st[b]) m_flip = 0;
                if (m_flip) m_nxt[b] = ~m_st[b];
            end
            m_w1c = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
            m_ecap = (m_ecap & ~m_w1c) | m_edges;
            m_st_prev = m_st;
            m_st = m_nxt;
            if (chipselect && !write_n) begin
                case (address)
                    3'd1: m_rise = writedata[W-1:0];
                    3'd2: m_mask = writedata[W-1:0];
                    3'd4: m_fall = writedata[W-1:0];
                    3'd5: begin m_deb = writedata[15:0]; last_clr = cyc; end
                    3'd6: m_mode = writedata[0];
                    default: ;
                endcase
            end
            if (rd_req) begin
                exp_a.push_back(int'(address));
                exp_d.push_back(m_rd);
                exp_irq.push_back(m_mode ? |(m_st & m_mask) : |(m_ecap & m_mask));
            end
        end
    end

    int mon_a;
    logic [31:0] mon_d;
    logic mon_i;
    always @(negedge clk) begin
        while (exp_d.size() > 0) begin
            mon_a = exp_a.pop_front();
            mon_d = exp_d.pop_front();
            mon_i = exp_irq.pop_front();
            checks++;
            if (readdata !== mon_d) begin
                errors++;
                $display("FAIL readdata addr=%0d t=%0t got=%h exp=%h", mon_a, $time, readdata, mon_d);
            end
            checks++;
            if (irq !== mon_i) begin
                errors++;
                $display("FAIL irq after read addr=%0d t=%0t got=%b exp=%b", mon_a, $time, irq, mon_i);
            end
        end
    end

    task automatic op(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = w; write_n = !w; writedata = d; rd_req = r;
    endtask
    task automatic do_rd(input logic [2:0] a); op(1'b1, 1'b0, a, 32'd0); endtask
    task automatic do_wr(input logic [2:0] a, input logic [31:0] d); op(1'b0, 1'b1, a, d); endtask
    task automatic do_idle(input int n); repeat (n) op(1'b0, 1'b0, 3'd0, 32'd0); endtask
    task automatic rd_n(input logic [2:0] a, input int n); repeat (n) do_rd(a); endtask

    int r;
    logic [2:0] ra;
    initial begin
        rd_n(0, 3);
        reset = 0;
        for (int a = 0; a < 8; a++) do_rd(3'(a));
        do_wr(1, 32'h01); do_wr(2, 32'h01);
        in_port[0] = 1;
        rd_n(0, 5); rd_n(3, 2);
        do_wr(3, 32'h01);
        rd_n(3, 2);
        do_wr(5, 5); do_wr(4, 32'h02);
        in_port[1] = 1;
        do_idle(12);
        do_wr(3, 32'hffff_ffff);
        in_port[1] = 0;
        rd_n(0, 4);
        in_port[1] = 1;
        rd_n(0, 10); rd_n(3, 1);
        in_port[1] = 0;
        rd_n(0, 5);
        in_port[1] = 1;
        rd_n(0, 10); rd_n(3, 2);
        do_wr(5, 0); do_wr(1, 32'h09); do_wr(3, 32'hff);
        do_idle(1);
        in_port[3] = 1;
        do_idle(2);
        do_wr(3, 32'h08);
        rd_n(3, 2);
        do_wr(6, 1); do_wr(2, 32'h80);
        in_port[7] = 1;
        rd_n(0, 6); rd_n(3, 1);
        in_port[7] = 0;
        rd_n(0, 6);
        do_wr(6, 0);
        do_wr(5, 5);
        in_port[2] = 1;
        rd_n(0, 3);
        reset = 1;
        in_port[2] = 0;
        do_rd(0);
        reset = 0;
        rd_n(0, 3); rd_n(3, 1); rd_n(5, 1);
        do_wr(1, 32'hff); do_wr(4, 32'hff);
        rd_n(3, 8); rd_n(0, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            r = int'($urandom_range(0, 99));
            ra = 3'($urandom_range(0, 7));
            if (r < 55) do_rd(ra);
            else if (r < 75) do_wr(ra, ra == 3'd5 ? 32'($urandom_range(0, 4)) : $urandom);
            else if (r < 76) begin reset = 1; do_idle(1); reset = 0; end
            else do_idle(1);
        end
        do_idle(3);
        checks++;
        if (exp_d.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain got=%0d pending exp=0", exp_d.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pio_edge_in_multi.md
Name: pio_edge_in_multi

Overview:
- Parametrised Avalon-MM input PIO and successor to the single-bit falling-edge capture PIO.
- Captures up to 32 input bits, each with a synchroniser, a per-bit debouncer and per-bit rising/falling edge enables.
- Captured edges are sticky and cleared by write-1-to-clear; the interrupt is maskable in edge or level mode.
- Sits on the HPS lightweight bridge for limit switches and encoder index inputs on the robot.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..4).
- DEB_W, 16, width of the debounce limit register and of each per-bit counter.
- DEB_RESET, 0, reset value of the DEBOUNCE register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values: every register, synchroniser flop, debounce counter, stable and stable_q bit is 0, except DEBOUNCE, which resets to DEB_RESET. readdata=0, irq=0.
- Register map (reads zero-extend to 32 bits; bits above WIDTH read 0 and ignore writes):
  - 0 DATA: stable vector, read-only.
  - 1 RISE_EN: rw.
  - 2 IRQ_MASK: rw.
  - 3 EDGE_CAPTURE: read, write-1-to-clear.
  - 4 FALL_EN: rw.
  - 5 DEBOUNCE: rw, DEB_W bits.
  - 6 IRQ_MODE: bit0; 0=edge, 1=level.
  - 7 reserved: reads 0, writes ignored.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. Readdata: updated every clock from the current address, so read latency is 1 cycle.
- Synchroniser: sync = in_port delayed SYNC_STAGES flops.
- Debounce, per bit, with effective limit L = max(DEBOUNCE,1):
  - If sync != stable: cnt increments. When cnt == L-1, stable <= sync and cnt <= 0.
  - If sync == stable: cnt <= 0.
  - So a change must persist L consecutive cycles. Any glitch shorter than L leaves stable unchanged.
  - Counters saturate-free: cnt never exceeds L-1.
  - A write to DEBOUNCE clears all counters in the same cycle.
- Latency: in_port step to DATA change = SYNC_STAGES + L cycles, plus 1 for readdata.
- Edge detect:
  - stable_q <= stable.
  - rise = stable & ~stable_q & RISE_EN.
  - fall = ~stable & stable_q & FALL_EN.
  - A bit with both enables captures either edge.
  - EDGE_CAPTURE[i] is set the cycle after rise|fall is seen and is sticky.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins (edge not lost). W1C of bit i does not affect other bits.
- Power-up edge: stable is 0 after reset, so an input held high through reset produces one rising edge after debounce. This is intended; software clears it at init.
- irq, combinational from registers only:
  - IRQ_MODE=0: irq = |(EDGE_CAPTURE & IRQ_MASK).
  - IRQ_MODE=1: irq = |(stable & IRQ_MASK).
- Reset asserted mid-debounce or mid-read: all state returns to reset values on that edge; no pending edge survives.
- Changing RISE_EN/FALL_EN does not clear EDGE_CAPTURE.

Test Plan:
- Reset, WIDTH=8, DEBOUNCE=0: read all 8 addresses -> readdata 0 everywhere except DEBOUNCE=DEB_RESET; irq=0.
- RISE_EN=0x01, IRQ_MASK=0x01, step in_port[0] 0->1 -> DATA[0]=1 after 3 cycles (SYNC_STAGES=2, L=1); EDGE_CAPTURE=0x01 one cycle later; irq=1. Write 0x01 to addr 3 -> EDGE_CAPTURE=0, irq=0.
- DEBOUNCE=5, FALL_EN=0x02: in_port[1] 1->0 pulse of 4 cycles -> no DATA change, no capture. Pulse of 5 cycles -> DATA[1]=0 and EDGE_CAPTURE=0x02.
- Edge arrives on bit 3 in the same cycle as a W1C of 0x08 -> EDGE_CAPTURE[3] remains 1.
- IRQ_MODE=1, IRQ_MASK=0x80: hold in_port[7]=1 -> irq=1 while DATA[7]=1; release -> irq=0 after SYNC_STAGES+L cycles, with EDGE_CAPTURE ignored.
- Assert reset during a debounce count on bit 2 -> cnt, stable and EDGE_CAPTURE all 0 next cycle; no spurious capture after release when input is low.
